kmkz_mem_arbiter: RTL and testbench

KMKZ_MEM_ARBITER -- requirements
Module: kmkz_mem_arbiter

---
 rtl/kmkz_mem_arbiter.sv | 85 ++++++++
 tb/tb_kmkz_mem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/kmkz_mem_arbiter.sv
// kmkz_mem_arbiter: single-outstanding memory arbiter between instruction fetch and data port with anti-starvation streak limit
module kmkz_mem_arbiter #(
  parameter int DATA_STREAK_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        if_flush_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);
  localparam int SW = (DATA_STREAK_MAX < 1) ? 1 : $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] SMAX = {SW{1'b1}};
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] streak;
  logic discard, grant_d, grant_f;
  always_comb begin
    grant_d   = d_req_i && !(if_req_i && streak >= SW'(DATA_STREAK_MAX));
    grant_f   = if_req_i && !grant_d;
    state_nxt = (state == IDLE) ? (grant_d ? DATA : grant_f ? FETCH : IDLE)
              : mem_ack_i ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  // Flush during the ack cycle counts too, so combine the live flush with the sticky flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      streak      <= '0;
      discard     <= 1'b0;
      if_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_ready_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      if_ready_o <= 1'b0;
      d_ready_o  <= 1'b0;
      if (state == IDLE) begin
        if (grant_d || grant_f) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= grant_d && d_we_i;
          mem_addr_o  <= grant_d ? d_addr_i : {if_addr_i[31:2], 2'b00};
          mem_wdata_o <= grant_d ? d_wdata_i : '0;
          mem_be_o    <= grant_d ? d_be_i : 4'hF;
        end
        if (grant_d) streak <= if_req_i ? streak + SW'(streak != SMAX) : '0;
        else if (grant_f) streak <= '0;
        discard <= grant_f && if_flush_i;
      end else if (mem_ack_i) begin
        mem_req_o <= 1'b0;
        discard   <= 1'b0;
        if (state == DATA) begin
          d_rdata_o <= mem_rdata_i;
          d_ready_o <= 1'b1;
        end else if (!(discard || if_flush_i)) begin
          if_rdata_o <= mem_rdata_i;
          if_ready_o <= 1'b1;
        end
      end else if (state == FETCH && if_flush_i) begin
        discard <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kmkz_mem_arbiter.sv
// tb_kmkz_mem_arbiter: directed self-checking bench for kmkz_mem_arbiter
module tb_kmkz_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, d_req_i, d_we_i, mem_ack_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ready_o, d_ready_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  int errors = 0;
  int checks = 0;
  logic [31:0] grant_seq [8];

  kmkz_mem_arbiter #(.DATA_STREAK_MAX(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o), .if_flush_i(if_flush_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    grant_seq = '{32'h800, 32'h800, 32'h800, 32'h900, 32'h800, 32'h800, 32'h800, 32'h900};
    rst_i = 1'b0; if_req_i = 0; if_flush_i = 0; d_req_i = 0; d_we_i = 0; mem_ack_i = 0;
    if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0; d_be_i = 0;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_readys", {30'd0, if_ready_o, d_ready_o}, 32'd0);
    chk("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);
    rst_i = 1'b1;
    // single fetch with two wait cycles
    if_req_i = 1; if_addr_i = 32'h103;
    tick();
    chk("f1_req", {31'd0, mem_req_o}, 32'd1);
    chk("f1_addr", mem_addr_o, 32'h100);
    chk("f1_be", {28'd0, mem_be_o}, 32'hF);
    chk("f1_we", {31'd0, mem_we_o}, 32'd0);
    tick(); tick();
    chk("f1_wait_ready", {31'd0, if_ready_o}, 32'd0);
    mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 0; if_req_i = 0;
    chk("f1_ready", {31'd0, if_ready_o}, 32'd1);
    chk("f1_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("f1_req_drop", {31'd0, mem_req_o}, 32'd0);
    tick();
    chk("f1_ready_pulse", {31'd0, if_ready_o}, 32'd0);
    chk("f1_no_regrant", {31'd0, mem_req_o}, 32'd0);
    // simultaneous: data write first, fetch after one idle cycle
    if_req_i = 1; if_addr_i = 32'h206;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'h55AA; d_be_i = 4'b0011;
    tick();
    chk("sim_d_addr", mem_addr_o, 32'h2000);
    chk("sim_d_we", {31'd0, mem_we_o}, 32'd1);
    chk("sim_d_wdata", mem_wdata_o, 32'h55AA);
    chk("sim_d_be", {28'd0, mem_be_o}, 32'h3);
    mem_ack_i = 1; mem_rdata_i = 32'h11112222;
    tick();
    mem_ack_i = 0; d_req_i = 0;
    chk("sim_d_ready", {31'd0, d_ready_o}, 32'd1);
    chk("sim_d_rdata", d_rdata_o, 32'h11112222);
    chk("sim_idle", {31'd0, mem_req_o}, 32'd0);
    tick();
    chk("sim_f_req", {31'd0, mem_req_o}, 32'd1);
    chk("sim_f_addr", mem_addr_o, 32'h204);
    chk("sim_f_we", {31'd0, mem_we_o}, 32'd0);
    chk("sim_f_be", {28'd0, mem_be_o}, 32'hF);
    mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    mem_ack_i = 0; if_req_i = 0;
    chk("sim_f_ready", {31'd0, if_ready_o}, 32'd1);
    chk("sim_f_rdata", if_rdata_o, 32'hCAFEF00D);
    tick();
    // flush during fetch wait, then a normal fetch
    if_req_i = 1; if_addr_i = 32'h300;
    tick();
    tick();
    if_flush_i = 1;
    tick();
    if_flush_i = 0;
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'hBADBAD00;
    tick();
    mem_ack_i = 0;
    chk("fl_no_ready", {31'd0, if_ready_o}, 32'd0);
    chk("fl_rdata_kept", if_rdata_o, 32'hCAFEF00D);
    chk("fl_ack_consumed", {31'd0, mem_req_o}, 32'd0);
    tick();
    chk("fl_next_req", {31'd0, mem_req_o}, 32'd1);
    chk("fl_next_addr", mem_addr_o, 32'h300);
    mem_ack_i = 1; mem_rdata_i = 32'h12345678;
    tick();
    mem_ack_i = 0; if_req_i = 0;
    chk("fl_next_ready", {31'd0, if_ready_o}, 32'd1);
    chk("fl_next_rdata", if_rdata_o, 32'h12345678);
    tick();
    // flush in the ack cycle suppresses that ready
    if_req_i = 1; if_addr_i = 32'h400;
    tick();
    mem_ack_i = 1; if_flush_i = 1; mem_rdata_i = 32'hAAAA5555;
    tick();
    mem_ack_i = 0; if_flush_i = 0; if_req_i = 0;
    chk("fla_no_ready", {31'd0, if_ready_o}, 32'd0);
    chk("fla_rdata_kept", if_rdata_o, 32'h12345678);
    tick();
    // starvation: D,D,D,F,D,D,D,F
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h800; if_req_i = 1; if_addr_i = 32'h900;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("stv_grant%0d", i), mem_addr_o, grant_seq[i]);
      mem_ack_i = 1; mem_rdata_i = 32'h5000 + i;
      tick();
      mem_ack_i = 0;
    end
    d_req_i = 0; if_req_i = 0;
    tick();
    // stability under a withheld ack; early request drop must not abort
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'hA00; d_wdata_i = 32'h0BADF00D; d_be_i = 4'b0101;
    tick();
    d_req_i = 0; d_addr_i = 32'hFFF0; d_wdata_i = 32'h0; d_be_i = 4'hF; if_req_i = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stb_addr", mem_addr_o, 32'hA00);
      chk("stb_wdata", mem_wdata_o, 32'h0BADF00D);
      chk("stb_be_we_req", {26'd0, mem_be_o, mem_we_o, mem_req_o}, {26'd0, 4'b0101, 1'b1, 1'b1});
      chk("stb_no_ready", {30'd0, if_ready_o, d_ready_o}, 32'd0);
    end
    mem_ack_i = 1; if_req_i = 0; mem_rdata_i = 32'h77;
    tick();
    mem_ack_i = 0;
    chk("stb_d_ready", {31'd0, d_ready_o}, 32'd1);
    chk("stb_d_rdata", d_rdata_o, 32'h77);
    tick();
    // asynchronous reset in the middle of a data transaction
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'hB00;
    tick();
    chk("rr_req_up", {31'd0, mem_req_o}, 32'd1);
    d_req_i = 0;
    #2 rst_i = 1'b0;
    #1;
    chk("rr_async_req", {31'd0, mem_req_o}, 32'd0);
    chk("rr_async_addr", mem_addr_o, 32'd0);
    chk("rr_async_rdata", if_rdata_o | d_rdata_o, 32'd0);
    tick();
    rst_i = 1'b1; mem_ack_i = 1;
    tick();
    mem_ack_i = 0;
    chk("rr_late_ack", {30'd0, d_ready_o, mem_req_o}, 32'd0);
    tick();
    chk("rr_after", {30'd0, d_ready_o, mem_req_o}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
